// File: rtl/mem_port_arbiter.sv
// Purpose: shares one line-wide memory port between ICache reads and DCache reads/writes; MEM_ARB_STATS_EN builds grant/conflict counters.
// Latency: strobes registered, asserted 1 cycle after a request is seen in IDLE; completions pass through combinationally; 1-cycle TURN after each ack.
// Backpressure: one outstanding transaction; the losing requester holds its level request until granted.
module mem_port_arbiter #(
    parameter int WORD_SIZE  = 16,
    parameter bit D_PRIORITY = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_readM,
    input  logic [WORD_SIZE-1:0]   i_address,
    output logic [4*WORD_SIZE-1:0] i_rdata,
    output logic                   i_input_readyM,
    input  logic                   d_readM,
    input  logic                   d_writeM,
    input  logic [WORD_SIZE-1:0]   d_address,
    input  logic [4*WORD_SIZE-1:0] d_wdata,
    output logic [4*WORD_SIZE-1:0] d_rdata,
    output logic                   d_input_readyM,
    output logic                   d_doneM,
    output logic                   m_readM,
    output logic                   m_writeM,
    output logic [WORD_SIZE-1:0]   m_address,
    output logic [4*WORD_SIZE-1:0] m_wdata,
    input  logic [4*WORD_SIZE-1:0] m_rdata,
    input  logic                   m_input_readyM,
    input  logic                   m_doneM,
    output logic                   busy,
    output logic [WORD_SIZE-1:0]   num_i_grant,
    output logic [WORD_SIZE-1:0]   num_d_grant,
    output logic [WORD_SIZE-1:0]   num_conflict
);

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, TURN} state_t;

    state_t                 state_q, state_d;
    logic                   last_d_q;      // 1 = D was granted last
    logic                   m_readM_q, m_writeM_q;
    logic [WORD_SIZE-1:0]   m_address_q;
    logic [4*WORD_SIZE-1:0] m_wdata_q;
    logic                   grant_i, grant_d_rd, grant_d_wr, ack_seen, tie;

    // Next-state and grant decode; write beats read when D raises both.
    always_comb begin
        state_d    = state_q;
        grant_i    = 1'b0;
        grant_d_rd = 1'b0;
        grant_d_wr = 1'b0;
        ack_seen   = 1'b0;
        tie        = i_readM && (d_readM || d_writeM);
        case (state_q)
            IDLE: begin
                if (i_readM && (!(d_readM || d_writeM) || !(D_PRIORITY || !last_d_q))) begin
                    grant_i = 1'b1;
                    state_d = I_RD;
                end else if (d_writeM) begin
                    grant_d_wr = 1'b1;
                    state_d    = D_WR;
                end else if (d_readM) begin
                    grant_d_rd = 1'b1;
                    state_d    = D_RD;
                end
            end
            I_RD, D_RD: begin
                if (m_input_readyM) begin
                    ack_seen = 1'b1;
                    state_d  = TURN;
                end
            end
            D_WR: begin
                if (m_doneM) begin
                    ack_seen = 1'b1;
                    state_d  = TURN;
                end
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, round-robin bit and registered memory-side strobes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            m_readM_q   <= 1'b0;
            m_writeM_q  <= 1'b0;
            m_address_q <= '0;
            m_wdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant_i) begin
                m_readM_q   <= 1'b1;
                m_address_q <= i_address;
                last_d_q    <= 1'b0;
            end else if (grant_d_rd) begin
                m_readM_q   <= 1'b1;
                m_address_q <= d_address;
                last_d_q    <= 1'b1;
            end else if (grant_d_wr) begin
                m_writeM_q  <= 1'b1;
                m_address_q <= d_address;
                m_wdata_q   <= d_wdata;
                last_d_q    <= 1'b1;
            end else if (ack_seen) begin
                m_readM_q  <= 1'b0;
                m_writeM_q <= 1'b0;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [WORD_SIZE-1:0] num_i_q, num_d_q, num_c_q;

    // Saturating grant and tie statistics.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            num_i_q <= '0;
            num_d_q <= '0;
            num_c_q <= '0;
        end else begin
            if (grant_i && num_i_q != '1)
                num_i_q <= num_i_q + 1'b1;
            if ((grant_d_rd || grant_d_wr) && num_d_q != '1)
                num_d_q <= num_d_q + 1'b1;
            if (state_q == IDLE && tie && num_c_q != '1)
                num_c_q <= num_c_q + 1'b1;
        end
    end

    assign num_i_grant  = num_i_q;
    assign num_d_grant  = num_d_q;
    assign num_conflict = num_c_q;
`else
    assign num_i_grant  = '0;
    assign num_d_grant  = '0;
    assign num_conflict = '0;
`endif

    // Completions only reach the granted side, and never while reset is held.
    assign i_input_readyM = reset_n && (state_q == I_RD) && m_input_readyM;
    assign d_input_readyM = reset_n && (state_q == D_RD) && m_input_readyM;
    assign d_doneM        = reset_n && (state_q == D_WR) && m_doneM;
    assign i_rdata        = m_rdata;
    assign d_rdata        = m_rdata;
    assign m_readM        = m_readM_q;
    assign m_writeM       = m_writeM_q;
    assign m_address      = m_address_q;
    assign m_wdata        = m_wdata_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_readM;
    logic [15:0] i_address;
    logic [63:0] i_rdata;
    logic        i_input_readyM;
    logic        d_readM, d_writeM;
    logic [15:0] d_address;
    logic [63:0] d_wdata, d_rdata;
    logic        d_input_readyM, d_doneM;
    logic        m_readM, m_writeM;
    logic [15:0] m_address;
    logic [63:0] m_wdata, m_rdata;
    logic        m_input_readyM, m_doneM;
    logic        busy;
    logic [15:0] num_i_grant, num_d_grant, num_conflict;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WORD_SIZE(16), .D_PRIORITY(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_readM(i_readM), .i_address(i_address), .i_rdata(i_rdata), .i_input_readyM(i_input_readyM),
        .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_input_readyM(d_input_readyM), .d_doneM(d_doneM),
        .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_input_readyM(m_input_readyM), .m_doneM(m_doneM),
        .busy(busy), .num_i_grant(num_i_grant), .num_d_grant(num_d_grant), .num_conflict(num_conflict)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one clock, then settle so registered outputs are stable
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pack the five status bits: {m_readM, m_writeM, i_input_readyM, d_input_readyM, d_doneM}
    function automatic logic [4:0] flags();
        return {m_readM, m_writeM, i_input_readyM, d_input_readyM, d_doneM};
    endfunction

    initial begin
        reset_n = 1'b0; i_readM = 1'b0; i_address = '0;
        d_readM = 1'b0; d_writeM = 1'b0; d_address = '0; d_wdata = '0;
        m_rdata = '0; m_input_readyM = 1'b0; m_doneM = 1'b0;
        tick(); tick();
        // reset state
        chk("rst_flags", 64'(flags()), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_addr", 64'(m_address), 64'h0);
        chk("rst_wdata", m_wdata, 64'h0);
        chk("rst_cnt", {16'h0, num_i_grant, num_d_grant, num_conflict}, 64'h0);
        reset_n = 1'b1;

        // I-only read of 0x0040, memory acks in the third grant cycle
        i_readM = 1'b1; i_address = 16'h0040;
        tick();
        chk("i_c1_flags", 64'(flags()), 64'b10000);
        chk("i_c1_addr", 64'(m_address), 64'h0040);
        chk("i_c1_busy", 64'(busy), 64'h1);
        tick();
        chk("i_c2_flags", 64'(flags()), 64'b10000);
        tick();
        m_rdata = 64'hAAAA_BBBB_CCCC_DDDD; m_input_readyM = 1'b1; #1;
        chk("i_c3_flags", 64'(flags()), 64'b10100);
        chk("i_c3_rdata", i_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
        tick();
        m_input_readyM = 1'b0; i_readM = 1'b0;
        chk("i_turn_flags", 64'(flags()), 64'b00000);
        chk("i_turn_busy", 64'(busy), 64'h1);
        tick();
        chk("i_idle_busy", 64'(busy), 64'h0);

        // D write of a line to 0x0100
        d_writeM = 1'b1; d_address = 16'h0100; d_wdata = 64'h1111_2222_3333_4444;
        tick();
        chk("dw_flags", 64'(flags()), 64'b01000);
        chk("dw_addr", 64'(m_address), 64'h0100);
        chk("dw_wdata", m_wdata, 64'h1111_2222_3333_4444);
        tick();
        m_doneM = 1'b1; #1;
        chk("dw_done", 64'(flags()), 64'b01001);
        tick();
        m_doneM = 1'b0; d_writeM = 1'b0;
        chk("dw_turn", 64'(flags()), 64'b00000);
        tick();

        // spurious acks: read-complete in IDLE, write-complete during I_RD
        m_input_readyM = 1'b1; #1;
        chk("sp_idle_flags", 64'(flags()), 64'b00000);
        tick();
        m_input_readyM = 1'b0;
        chk("sp_idle_busy", 64'(busy), 64'h0);
        i_readM = 1'b1; i_address = 16'h0080;
        tick();
        m_doneM = 1'b1; #1;
        chk("sp_ird_flags", 64'(flags()), 64'b10000);
        tick();
        m_doneM = 1'b0;
        chk("sp_ird_stay", 64'({busy, flags()}), 64'b110000);
        m_input_readyM = 1'b1; #1;
        chk("sp_ird_ack", 64'(flags()), 64'b10100);
        tick();
        m_input_readyM = 1'b0; i_readM = 1'b0;
        tick();

        // reset in the middle of a D read, late ack ignored, then normal I read
        d_readM = 1'b1; d_address = 16'h0200;
        tick();
        chk("dr_flags", 64'(flags()), 64'b10000);
        chk("dr_addr", 64'(m_address), 64'h0200);
        reset_n = 1'b0; d_readM = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mr_flags", 64'({busy, flags()}), 64'h0);
        chk("mr_addr", 64'(m_address), 64'h0);
        m_input_readyM = 1'b1; #1;
        chk("mr_late", 64'(flags()), 64'b00000);
        tick();
        m_input_readyM = 1'b0;
        chk("mr_late_busy", 64'(busy), 64'h0);
        i_readM = 1'b1; i_address = 16'h0300;
        tick();
        chk("mr_i_addr", 64'({m_readM, m_address}), {47'h0, 1'b1, 16'h0300});
        m_rdata = 64'h0123_4567_89AB_CDEF; m_input_readyM = 1'b1; #1;
        chk("mr_i_ack", 64'(flags()), 64'b10100);
        chk("mr_i_rdata", i_rdata, 64'h0123_4567_89AB_CDEF);
        tick();
        m_input_readyM = 1'b0; i_readM = 1'b0;
        tick();

        // read and write together from D: write wins
        d_readM = 1'b1; d_writeM = 1'b1; d_address = 16'h0400; d_wdata = 64'h5555_6666_7777_8888;
        tick();
        chk("rw_flags", 64'(flags()), 64'b01000);
        chk("rw_wdata", m_wdata, 64'h5555_6666_7777_8888);
        m_doneM = 1'b1; #1;
        chk("rw_done", 64'(flags()), 64'b01001);
        tick();
        m_doneM = 1'b0; d_readM = 1'b0; d_writeM = 1'b0;
        tick();

        // both sides requesting continuously from reset: I, D, I, D
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        i_readM = 1'b1; i_address = 16'h0010;
        d_readM = 1'b1; d_address = 16'h0020;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk($sformatf("rr%0d_addr", g), 64'(m_address), (g % 2 == 0) ? 64'h0010 : 64'h0020);
            m_input_readyM = 1'b1; #1;
            chk($sformatf("rr%0d_pulse", g), 64'(flags()), (g % 2 == 0) ? 64'b10100 : 64'b10010);
            tick();
            m_input_readyM = 1'b0;
            tick();
        end
        i_readM = 1'b0; d_readM = 1'b0;
`ifdef MEM_ARB_STATS_EN
        chk("st_cnt", {16'h0, num_i_grant, num_d_grant, num_conflict}, {16'h0, 16'd2, 16'd2, 16'd4});
`else
        chk("st_cnt", {16'h0, num_i_grant, num_d_grant, num_conflict}, 64'h0);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one line-wide (4-word) memory port between the ICache miss path and the DCache miss/writeback path.
- Sits between the two cache instances and the memory model.
- Grants exactly one outstanding transaction at a time, using round-robin on ties.
- Routes the memory's read-data and completion pulses back to the granted cache only.

Parameters:
- WORD_SIZE, 16, address and data word width; line width is 4*WORD_SIZE.
- D_PRIORITY, 0, 1 = D side always wins ties; 0 = round-robin on ties.

Ports:
- clk  input  1  clock
- reset_n  input  1  reset; synchronous, active-low
- i_readM  input  1  ICache line read request (level)
- i_address  input  WORD_SIZE  ICache line address
- i_rdata  output  4*WORD_SIZE  line returned to ICache
- i_input_readyM  output  1  one-cycle read-complete pulse to ICache
- d_readM  input  1  DCache line read request (level)
- d_writeM  input  1  DCache write request (level)
- d_address  input  WORD_SIZE  DCache address
- d_wdata  input  4*WORD_SIZE  DCache write data
- d_rdata  output  4*WORD_SIZE  line returned to DCache
- d_input_readyM  output  1  one-cycle read-complete pulse to DCache
- d_doneM  output  1  one-cycle write-complete pulse to DCache
- m_readM  output  1  memory read strobe
- m_writeM  output  1  memory write strobe
- m_address  output  WORD_SIZE  memory address
- m_wdata  output  4*WORD_SIZE  memory write data
- m_rdata  input  4*WORD_SIZE  memory read data
- m_input_readyM  input  1  memory read-complete pulse
- m_doneM  input  1  memory write-complete pulse
- busy  output  1  high in any state other than IDLE
- num_i_grant  output  WORD_SIZE  statistics (see Optional Feature)
- num_d_grant  output  WORD_SIZE  statistics
- num_conflict  output  WORD_SIZE  statistics

Behaviour:
- States: IDLE, I_RD, D_RD, D_WR, TURN. Reset state is IDLE.
- Reset: clears state and the rr bit (last_grant = D, so I wins the first tie).
  - All outputs 0: m_readM, m_writeM, m_address, m_wdata, busy, counters, and all pulses.
- Reset mid-transaction: the transaction is abandoned; memory acks arriving after reset are ignored.
- Requesters hold request, address and data stable until their completion pulse.
- If d_readM and d_writeM are both high, the write wins (illegal input; must not hang).
- IDLE transitions:
  - Only I requesting -> I_RD.
  - Only D requesting -> D_RD or D_WR.
  - Both requesting -> the side not granted last (or D if D_PRIORITY=1); update last_grant.
  - No request -> stay in IDLE.
- m_* strobes, address and data are registered.
  - They are asserted from the first cycle in I_RD, D_RD or D_WR, i.e. 1 cycle after the request is seen in IDLE.
  - They hold until the matching ack.
- In I_RD:
  - m_input_readyM drives i_input_readyM combinationally in the same cycle, with i_rdata = m_rdata.
  - Next state is TURN; strobes deassert at that edge.
- In D_RD: same as I_RD, but on d_input_readyM / d_rdata.
- In D_WR: m_doneM drives d_doneM combinationally; next state is TURN.
- Ignored acks:
  - Acks of the wrong kind (e.g. doneM in I_RD).
  - Any ack seen in IDLE or TURN.
  - Completion outputs stay 0 in these cases.
- TURN lasts exactly 1 cycle and ignores requests, so requesters can drop their request; then -> IDLE.
- Minimum request-to-request spacing for one requester: 1 (grant) + memory latency + 1 (TURN) cycles.
- i_rdata and d_rdata pass m_rdata through continuously.
  - Only the side whose pulse is asserted may consume it.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - num_i_grant increments on each grant to I (entering I_RD).
  - num_d_grant increments on each grant to D (entering D_RD or D_WR).
  - num_conflict increments on every IDLE cycle with both sides requesting.
  - All three saturate at 16'hFFFF and clear on reset.
- Undefined: the ports remain and are tied to 0; no counter flops are built.

Test Plan:
- I-only read to 16'h0040, memory acks after 3 cycles -> m_readM high for cycles 1-3 with m_address=0040; i_input_readyM pulses once with the line; d_* pulses stay 0; TURN, then IDLE.
- D write to 16'h0100 with data 64'h1111_2222_3333_4444 -> m_writeM and m_wdata match; d_doneM pulses in the same cycle as m_doneM; no read pulses.
- Both requesting continuously from reset, D_PRIORITY=0 -> grants alternate I, D, I, D; with MEM_ARB_STATS_EN, num_conflict counts each tied IDLE cycle.
- Spurious m_doneM during I_RD, and m_input_readyM in IDLE -> no completion pulse, no state change.
- reset_n low for one cycle during D_RD -> next cycle IDLE with all m_* = 0; a late m_input_readyM is ignored; the following I request is served normally.
- d_readM and d_writeM both high -> D_WR is entered; completion arrives on d_doneM only.
